// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and the fetch-entry record used by the
// fetch unit, its queues and anything that observes decoded fetch entries.
package fetch_pkg;

  localparam int unsigned        ADDR_W    = 32;
  localparam int unsigned        INSTR_W   = 32;
  localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;
  localparam int unsigned        PC_STEP   = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; used both as the PC-tag
// FIFO for outstanding requests and as the instruction queue towards decode.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  import fetch_pkg::*;

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_q <= ptr_inc(rd_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with credit-limited memory requests, an
// in-order fetch queue towards decode, and redirect with in-flight drop.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = fetch_pkg::ADDR_W,
  parameter int unsigned       INSTR_W  = fetch_pkg::INSTR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       MAX_OUT  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int unsigned       PC_STEP  = fetch_pkg::PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  pc
);
  import fetch_pkg::*;

  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned QW = $clog2(DEPTH + 1);
  localparam int unsigned SW = ((OW > QW) ? OW : QW) + 1;
  localparam int unsigned EW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OW-1:0]     drop_q, drop_d;
  logic [OW-1:0]     outstanding;
  logic [QW-1:0]     occupancy;
  logic [SW-1:0]     credit_used;
  logic              fire, resp_take, q_pop;
  logic              tag_full, tag_empty, q_full, q_empty;
  logic [ADDR_W-1:0] resp_tag;
  logic [EW-1:0]     q_head;

  // Outstanding requests are tracked by the tag FIFO occupancy itself.
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (1'b0),
    .push_i  (fire),
    .din_i   (pc_q),
    .pop_i   (imem_resp_valid),
    .dout_o  (resp_tag),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (outstanding)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (redirect_valid),
    .push_i  (resp_take),
    .din_i   ({resp_tag, imem_resp_data}),
    .pop_i   (q_pop),
    .dout_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (occupancy)
  );

  assign credit_used    = SW'(outstanding) + SW'(occupancy);
  assign imem_req_valid = reset && !redirect_valid && !tag_full
                          && (credit_used < SW'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign fire           = imem_req_valid && imem_req_ready;

  assign resp_take = imem_resp_valid && (drop_q == '0) && !redirect_valid;

  assign out_valid = !q_empty;
  assign q_pop     = out_valid && out_ready;
  assign out_pc    = q_head[EW-1:INSTR_W];
  assign out_instr = q_head[INSTR_W-1:0];

  // On redirect every request still in flight after this cycle is stale.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[ADDR_W-1:2], 2'b00};
      drop_d = outstanding - OW'(imem_resp_valid);
    end else begin
      if (fire) begin
        pc_d = pc_q + ADDR_W'(PC_STEP);
      end
      if (imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - OW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  a_resp_has_tag : assert property (
    @(posedge clk) disable iff (!reset) imem_resp_valid |-> !tag_empty);

  a_queue_no_overflow : assert property (
    @(posedge clk) disable iff (!reset) resp_take |-> (!q_full || q_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a program-order model:
// after reset or a redirect, requests and decoded entries walk PCs by 4.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc, pc;

  fetch_unit #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .DEPTH    (4),
    .MAX_OUT  (4),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .pc              (pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  int n_fire = 0;
  int n_out  = 0;
  int first_resp = -1;
  int first_out  = -1;

  int          due_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] exp_req, exp_out;
  logic        prev_hold;
  fetch_entry_t prev_head;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ NOP_INSTR;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, then let the memory model drive
  // the next response just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (redirect_valid) chk("req_masked_on_redirect", 64'(imem_req_valid), 64'd0);
    if (imem_resp_valid && first_resp < 0) first_resp = cyc;
    if (out_valid && first_out < 0) first_out = cyc;
    if (prev_hold) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_pc", 64'(out_pc), 64'(prev_head.pc));
      chk("hold_instr", 64'(out_instr), 64'(prev_head.instr));
    end
    if (out_valid && out_ready) begin
      chk("out_pc", 64'(out_pc), 64'(exp_out));
      chk("out_instr", 64'(out_instr), 64'(mem_word(exp_out)));
      exp_out += 32'd4;
      n_out++;
    end
    prev_hold       = out_valid && !out_ready && !redirect_valid;
    prev_head.pc    = out_pc;
    prev_head.instr = out_instr;
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", 64'(imem_req_addr), 64'(exp_req));
      due_q.push_back(cyc + lat);
      addr_q.push_back(imem_req_addr);
      exp_req += 32'd4;
      n_fire++;
    end
    if (imem_resp_valid) begin
      void'(due_q.pop_front());
      void'(addr_q.pop_front());
    end
    if (redirect_valid) begin
      exp_req = redirect_pc & ~32'h3;
      exp_out = exp_req;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(addr_q[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int o0;
    reset           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b0;
    exp_req         = 32'h0;
    exp_out         = 32'h0;
    prev_hold       = 1'b0;
    prev_head       = '0;

    #2;
    chk("reset_pc", 64'(pc), 64'h0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_req_valid", 64'(imem_req_valid), 64'd0);
    chk("reset_out_instr", 64'(out_instr), 64'd0);
    chk("reset_out_pc", 64'(out_pc), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Latency-1 memory, decode always ready: straight-line stream from 0x0.
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    lat            = 1;
    repeat (12) tick();
    chk("first_out_latency", 64'(first_out - first_resp), 64'd1);
    chk("stream_progress", 64'(n_out >= 8), 64'd1);

    // Decode stalled after restarting at 0x0: queue fills with exactly DEPTH entries.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    f0 = n_fire;
    repeat (15) tick();
    chk("stall_fire_count", 64'(n_fire - f0), 64'd4);
    chk("stall_req_blocked", 64'(imem_req_valid), 64'd0);
    chk("stall_head_valid", 64'(out_valid), 64'd1);
    chk("stall_head_pc", 64'(out_pc), 64'h0);
    chk("stall_next_pc", 64'(pc), 64'h10);
    out_ready = 1'b1;
    o0 = n_out;
    repeat (10) tick();
    chk("stall_release_progress", 64'(n_out >= o0 + 5), 64'd1);

    // Latency 3 keeps three requests in flight; redirect must drop all of them.
    lat = 3;
    repeat (8) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    o0 = n_out;
    for (int k = 0; k < 40 && n_out < o0 + 2; k++) tick();
    chk("redirect_stream_resumed", 64'(n_out >= o0 + 2), 64'd1);

    // Misaligned target is forced to a word boundary.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    chk("redirect_aligned_pc", 64'(pc), 64'h200);
    repeat (10) tick();

    // PC wrap-around at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    o0 = n_out;
    repeat (12) tick();
    chk("wrap_progress", 64'(n_out >= o0 + 4), 64'd1);

    // Request-ready toggling must neither skip nor repeat a PC.
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      imem_req_ready = (i % 2 == 0);
      tick();
    end
    imem_req_ready = 1'b1;

    // Random backpressure, latencies and (sometimes back-to-back) redirects.
    o0 = n_out;
    for (int i = 0; i < 600; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 9) < 7);
      lat            = $urandom_range(1, 4);
      if (redirect_valid && $urandom_range(0, 1) == 1) begin
        redirect_pc = $urandom;
      end else if ($urandom_range(0, 99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    lat            = 1;
    repeat (10) tick();
    chk("random_progress", 64'(n_out >= o0 + 100), 64'd1);

    // Asynchronous reset in the middle of a running stream.
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_req_valid", 64'(imem_req_valid), 64'd0);
    chk("midreset_pc", 64'(pc), 64'h0);
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    due_q.delete();
    addr_q.delete();
    exp_req   = 32'h0;
    exp_out   = 32'h0;
    prev_hold = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    f0 = n_fire;
    o0 = n_out;
    repeat (10) tick();
    chk("post_reset_fires", 64'(n_fire > f0), 64'd1);
    chk("post_reset_outs", 64'(n_out >= o0 + 6), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
